// File: rtl/blit_pkg.sv
// blit_pkg: shared FSM encodings and baud divider helpers for the blit UART blocks
// ST_* : 2-bit transmit FSM state encodings
// DIV_MIN : smallest legal clocks-per-bit ratio
// blit_div : integer-truncated clocks-per-bit for a given clock and baud rate
package blit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DIV_MIN = 2;

    function automatic int blit_div(input int hz, input int baud);
        return hz / baud;
    endfunction

endpackage

// File: rtl/blit_fifo.sv
// blit_fifo: synchronous byte FIFO shared by the blit UART transmit and receive paths
// clk, rstn        : clock, asynchronous active-low reset
// push_i, wdata_i  : write strobe and data (ignored when full)
// pop_i, rdata_o   : read strobe (ignored when empty) and head-of-queue data
// count_o          : registered occupancy, 0..DEPTH
// full_o, empty_o  : occupancy flags decoded from count_o
module blit_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("blit_fifo: DEPTH must be a power of two and at least 2");
    end

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset: only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/blit_uart_tx.sv
// blit_uart_tx: FIFO-buffered 8N1 UART transmitter
// clk, rstn          : clock, asynchronous active-low reset
// in_valid, in_data  : byte offered by upstream, held until accepted
// in_ready           : byte accepted on this edge when in_valid is high
// tx                 : registered serial line, idle high
// busy               : registered, high while a byte is queued or in flight
module blit_uart_tx
    import blit_pkg::*;
#(
    parameter int HZ    = 100_000_000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = blit_div(HZ, BAUD);
    localparam int BW  = $clog2(DIV);

    logic [1:0]             state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             sh_q, sh_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   pop;
    logic                   tick;
    logic                   full;
    logic                   empty;
    logic [7:0]             head;
    logic [$clog2(DEPTH):0] cnt;

    if (DIV < DIV_MIN) begin : g_bad_div
        $error("blit_uart_tx: HZ/BAUD must be at least 2");
    end

    blit_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (in_valid && in_ready),
        .wdata_i(in_data),
        .pop_i  (pop),
        .rdata_o(head),
        .count_o(cnt),
        .full_o (full),
        .empty_o(empty)
    );

    assign in_ready = !full;
    assign tick     = baud_q == '0;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // The baud counter free-runs through every bit cell and reloads on each boundary;
    // leaving IDLE reloads it explicitly so the start bit gets a full DIV cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = state_q == ST_IDLE ? baud_q : tick ? BW'(DIV - 1) : baud_q - 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    bit_d   = 3'd0;
                    baud_d  = BW'(DIV - 1);
                    state_d = ST_START;
                end
            end
            ST_START: state_d = tick ? ST_DATA : ST_START;
            ST_DATA: begin
                if (tick) begin
                    sh_d    = sh_q >> 1;
                    bit_d   = bit_q == 3'd7 ? bit_q : bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? ST_STOP : ST_DATA;
                end
            end
            default: begin
                // End of stop bit chains straight into the next start bit when bytes wait.
                if (tick) begin
                    pop     = !empty;
                    sh_d    = empty ? sh_q : head;
                    bit_d   = 3'd0;
                    state_d = empty ? ST_IDLE : ST_START;
                end
            end
        endcase
    end

    // tx is driven from the current state, so the line lags the FSM by one cycle.
    assign tx_d   = state_q == ST_START ? 1'b0 : state_q == ST_DATA ? sh_q[0] : 1'b1;
    assign busy_d = state_q != ST_IDLE || cnt != '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_blit_uart_tx.sv
// tb_blit_uart_tx: directed self-checking bench for blit_uart_tx
module tb_blit_uart_tx;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       v2;
    logic [7:0] d2;
    logic       rdy2;
    logic       tx2;
    logic       busy2;
    logic [7:0] rxq [$];
    logic [7:0] rb;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n;
    int         m;
    int         acc;
    int         low;
    logic       lvl;

    blit_uart_tx #(.HZ(800), .BAUD(100), .DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .busy(busy)
    );

    blit_uart_tx dut2 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_data(d2),
        .in_ready(rdy2), .tx(tx2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial receiver for the DIV=8 instance: mid-bit sampling on the falling clock edge.
    always begin
        @(negedge clk);
        if (rstn && tx === 1'b0) begin
            repeat (4) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (8) @(negedge clk);
                rb[k] = tx;
            end
            repeat (8) @(negedge clk);
            rxq.push_back(tx === 1'b1 ? rb : ~rb);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input bit sel, input int lim, output int cnt);
        cnt = 0;
        while ((sel ? tx2 : tx) !== 1'b0 && cnt < lim) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_rx(input int k, input int lim);
        int c;
        c = 0;
        while (rxq.size() < k && c < lim) begin
            step();
            c++;
        end
    endtask

    task automatic frame(input logic [7:0] b, input string tag);
        logic [7:0] s;
        logic       e;
        for (int k = 0; k < 10; k++) begin
            e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
            for (int c = 0; c < 8; c++) begin
                s[c] = tx;
                step();
            end
            check($sformatf("%s_bit%0d", tag, k), s, {8{e}});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        v2 = 1'b0;
        d2 = 8'h00;
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_tx2", tx2, 1);
        rstn = 1'b1;

        in_valid = 1'b1;
        in_data = 8'h55;
        step();
        in_valid = 1'b0;
        wait_fall(0, 20, n);
        check("lat55", n, 2);
        check("busy55", busy, 1);
        frame(8'h55, "f55");
        check("idle55_busy", busy, 0);
        check("idle55_tx", tx, 1);

        in_valid = 1'b1;
        in_data = 8'h00;
        step();
        in_data = 8'hFF;
        step();
        in_valid = 1'b0;
        wait_fall(0, 20, n);
        check("lat00", n, 1);
        frame(8'h00, "f00");
        frame(8'hFF, "fFF");
        check("idleFF_busy", busy, 0);

        rxq.delete();
        repeat (2) step();
        in_valid = 1'b1;
        in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        in_valid = 1'b1;
        in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        wait_rx(2, 400);
        repeat (100) step();
        check("gap_cnt", rxq.size(), 2);
        check("gap_A5", rxq.size() > 0 ? rxq[0] : 8'h00, 8'hA5);
        check("gap_3C", rxq.size() > 1 ? rxq[1] : 8'h00, 8'h3C);
        check("gap_busy", busy, 0);

        rxq.delete();
        rstn = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h10;
        step();
        check("rst2_ready", in_ready, 1);
        step();
        rstn = 1'b1;
        acc = 0;
        while (in_ready && acc < 40) begin
            step();
            acc++;
            in_data = in_data + 8'h01;
        end
        check("fill_acc", acc, 17);
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        check("fill_wait", n, 65);
        check("fill_stop_tx", tx, 1);
        step();
        check("fill_reful", in_ready, 0);
        check("fill_start_tx", tx, 0);
        in_valid = 1'b0;
        wait_rx(18, 18 * 80 + 300);
        check("fill_cnt", rxq.size(), 18);
        for (int i = 0; i < 18; i++)
            check($sformatf("fill_ord%0d", i), i < rxq.size() ? rxq[i] : 8'h00, 8'h10 + i);

        in_valid = 1'b1;
        in_data = 8'h00;
        step();
        in_data = 8'h77;
        step();
        in_valid = 1'b0;
        wait_fall(0, 20, n);
        check("abort_lat", n, 1);
        repeat (34) step();
        check("abort_b3", tx, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        low = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx !== 1'b1) low++;
        end
        check("abort_quiet", low, 0);
        check("abort_idle", busy, 0);
        rxq.delete();
        in_valid = 1'b1;
        in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        wait_fall(0, 20, n);
        check("post_lat", n, 2);
        wait_rx(1, 200);
        repeat (20) step();
        check("post_cnt", rxq.size(), 1);
        check("post_5A", rxq.size() > 0 ? rxq[0] : 8'h00, 8'h5A);

        v2 = 1'b1;
        d2 = 8'h55;
        step();
        v2 = 1'b0;
        wait_fall(1, 20, n);
        check("div868_lat", n, 2);
        for (int r = 0; r < 9; r++) begin
            lvl = tx2;
            m = 0;
            while (tx2 === lvl && m < 2000) begin
                step();
                m++;
            end
            check($sformatf("div868_bit%0d", r), m, 868);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
